// File: rtl/nic_port_lookup_pkg.sv
// Shared IOQ header layout, state encoding and port-pairing
// helpers for the output-port-lookup stage.
package nic_port_lookup_pkg;

  localparam logic [7:0] IOQ_CTRL_WORD = 8'hFF;
  localparam int IOQ_W        = 64;
  localparam int FIELD_W      = 16;
  localparam int WORD_LEN_POS = 48;
  localparam int DST_PORT_POS = 32;
  localparam int BYTE_LEN_POS = 16;
  localparam int SRC_PORT_POS = 0;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } lookup_state_t;

  function automatic logic ioq_src_ok(
    input logic [IOQ_W-1:0] hdr,
    input int unsigned      nq
  );
    return 32'(hdr[SRC_PORT_POS +: FIELD_W]) < nq;
  endfunction

  // MAC port 2n <-> CPU port 2n+1; bad source clears the destination
  function automatic logic [IOQ_W-1:0] ioq_rewrite(
    input logic [IOQ_W-1:0] hdr,
    input int unsigned      nq
  );
    logic [FIELD_W-1:0] src;
    logic [IOQ_W-1:0]   r;
    src = hdr[SRC_PORT_POS +: FIELD_W];
    r = '0;
    r[WORD_LEN_POS +: FIELD_W] = hdr[WORD_LEN_POS +: FIELD_W];
    r[BYTE_LEN_POS +: FIELD_W] = hdr[BYTE_LEN_POS +: FIELD_W];
    r[SRC_PORT_POS +: FIELD_W] = src;
    r[DST_PORT_POS +: FIELD_W] = ioq_src_ok(hdr, nq)
      ? (FIELD_W'(1) << (src ^ FIELD_W'(1)))
      : '0;
    return r;
  endfunction

endpackage

// File: rtl/nic_port_lookup_fifo.sv
// Show-ahead input buffer; nearly_full leaves one word of
// slack for a writer that reacts a cycle late.
module nic_port_lookup_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             nearly_full
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] NF_LVL =
    (DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [DEPTH_BITS:0] ONE =
    (DEPTH_BITS+1)'(1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic [DEPTH_BITS:0] used;
  logic                full;
  logic                wr_ok;
  logic                rd_ok;

  assign used        = wr_ptr - rd_ptr;
  assign full        = used[DEPTH_BITS];
  assign empty       = (used == '0);
  assign nearly_full = (used >= NF_LVL);
  assign wr_ok       = wr_en & ~full;
  assign rd_ok       = rd_en & ~empty;
  assign dout        = mem[rd_ptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[DEPTH_BITS-1:0]] <= din;
  end

endmodule

// File: rtl/nic_port_lookup.sv
// Output-port lookup: pairs MAC/CPU ports in the IOQ header
// and zeroes the destination of malformed packets.
module nic_port_lookup
  import nic_port_lookup_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int FIFO_DEPTH_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [31:0]           fwd_pkt_cnt,
  output logic [31:0]           drop_pkt_cnt
);

  localparam int FW = CTRL_WIDTH + DATA_WIDTH;

  logic [FW-1:0]         fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_nf;
  logic                  pop;
  logic [CTRL_WIDTH-1:0] pop_ctrl;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  is_ioq;
  logic                  is_data;

  lookup_state_t state, nxt_state;
  logic seen_ioq, nxt_seen;
  logic pkt_bad, nxt_bad;
  logic last_word, last_bad;

  nic_port_lookup_fifo #(
    .WIDTH      (FW),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .nearly_full (fifo_nf)
  );

  assign {pop_ctrl, pop_data} = fifo_dout;
  assign pop     = ~fifo_empty & out_rdy;
  assign in_rdy  = reset & ~fifo_nf;
  assign is_ioq  = (pop_ctrl == CTRL_WIDTH'(IOQ_CTRL_WORD));
  assign is_data = (pop_ctrl == '0);

  always_comb begin
    nxt_state = state;
    nxt_seen  = seen_ioq;
    nxt_bad   = pkt_bad;
    nxt_data  = pop_data;
    last_word = 1'b0;
    last_bad  = 1'b0;
    if (pop) begin
      unique case (state)
        HDR: begin
          unique case (1'b1)
            is_ioq: begin
              nxt_data[IOQ_W-1:0] = ioq_rewrite(
                pop_data[IOQ_W-1:0], NUM_OUTPUT_QUEUES);
              nxt_seen = 1'b1;
              if (!ioq_src_ok(pop_data[IOQ_W-1:0],
                              NUM_OUTPUT_QUEUES))
                nxt_bad = 1'b1;
            end
            is_data: nxt_state = PAYLOAD;
            default: ;
          endcase
        end
        PAYLOAD: begin
          if (!is_data) begin
            last_word = 1'b1;
            last_bad  = pkt_bad | ~seen_ioq;
            nxt_state = HDR;
            nxt_seen  = 1'b0;
            nxt_bad   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HDR;
      seen_ioq     <= 1'b0;
      pkt_bad      <= 1'b0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      fwd_pkt_cnt  <= '0;
      drop_pkt_cnt <= '0;
    end else begin
      state    <= nxt_state;
      seen_ioq <= nxt_seen;
      pkt_bad  <= nxt_bad;
      out_wr   <= pop;
      if (pop) begin
        out_data <= nxt_data;
        out_ctrl <= pop_ctrl;
      end
      if (last_word) begin
        if (last_bad)
          drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
        else
          fwd_pkt_cnt <= fwd_pkt_cnt + 32'd1;
      end
    end
  end

endmodule
